// File: rtl/b16_uart_rx_if.sv
// b16 I/O bus view of the UART receiver: register select, read strobe,
// read data and interrupt.
interface b16_uart_rx_if;
  logic        sel;
  logic        rd;
  logic        a;
  logic [15:0] dout;
  logic        irq;

  modport master (output sel, rd, a, input dout, irq);
  modport slave  (input sel, rd, a, output dout, irq);
endinterface

// File: rtl/b16_uart_rx.sv
// 8N1 serial receiver with a small byte FIFO and data/status registers on the b16 bus.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module b16_uart_rx #(
  parameter int unsigned DIV       = 87,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          rxd,
  b16_uart_rx_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned PW    = DEPTH_LOG + 1;

  localparam logic [CW-1:0]        CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0]        CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]        FIFO_MAX = PW'(DEPTH);
  localparam logic [PW-1:0]        FIFO_ONE = PW'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        count_q, count_d;
  logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                 irq_q, irq_d, rd_prev_q, rd_prev_d;

  logic tick, push_req, ferr_set, perr_set;
  logic rd_act, fire, empty, full, pop, clr, push, ovr_set;
  logic [15:0] status, data;

  always_comb begin
    rx_s1_d   = rxd;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    tick     = (cnt_q == '0);
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!rx_s2_q) begin
          state_d = S_DATA;
          bit_d   = '0;
          cnt_d   = CNT_FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          perr_set = ^{shift_q, rx_s2_q};
          cnt_d    = CNT_FULL;
          state_d  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s2_q) begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    rd_act    = bus.sel & bus.rd;
    rd_prev_d = rd_act;
    fire      = rd_act & ~rd_prev_q;
    empty     = (count_q == '0);
    full      = (count_q == FIFO_MAX);
    pop       = fire & ~bus.a & ~empty;
    clr       = fire & bus.a;
    push      = push_req & (~full | pop);
    ovr_set   = push_req & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + FIFO_ONE;
      2'b01:   count_d = count_q - FIFO_ONE;
      default: count_d = count_q;
    endcase

    ovr_d  = (ovr_q  & ~clr) | ovr_set;
    ferr_d = (ferr_q & ~clr) | ferr_set;
    perr_d = (perr_q & ~clr) | perr_set;
    irq_d  = (count_d != '0);
  end

  always_comb begin
    status = {8'h00, (state_q != S_IDLE), perr_q, ferr_q, ovr_q, 3'(count_q), ~empty};
    data   = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
  end

  assign bus.dout = bus.a ? status : data;
  assign bus.irq  = irq_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      irq_q     <= irq_d;
      rd_prev_q <= rd_prev_d;
    end
  end
endmodule

// File: tb/tb_b16_uart_rx.sv
// Scoreboard bench for b16_uart_rx: serial frames in, register reads out.
// Honours UART_RX_PARITY_EN to add the parity bit and the parity scenario.
module tb_b16_uart_rx;
  localparam int unsigned DIV = 87;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = 11;
  logic par_flip = 1'b0;
`else
  localparam int unsigned NB = 10;
`endif
  // negedges from the start-bit negedge to the one before the stop-sample posedge
  localparam int unsigned STOP_NEG = 2 + DIV / 2 + DIV * (NB - 1);

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic rxd = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  b16_uart_rx_if bus_if ();

  b16_uart_rx #(.DIV(DIV), .DEPTH_LOG(2)) dut (
    .clk(clk), .reset_b(reset_b), .rxd(rxd), .bus(bus_if)
  );

  always #50 clk = ~clk;

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^data) ^ par_flip;
    repeat (DIV) @(negedge clk);
`endif
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic peek(input logic sel_a, output logic [15:0] v);
    @(negedge clk);
    bus_if.a = sel_a;
    bus_if.sel = 1'b1;
    bus_if.rd = 1'b0;
    #10 v = bus_if.dout;
    bus_if.sel = 1'b0;
  endtask

  task automatic read_reg(input logic sel_a, output logic [15:0] v);
    @(negedge clk);
    bus_if.a = sel_a;
    bus_if.sel = 1'b1;
    bus_if.rd = 1'b1;
    #10 v = bus_if.dout;
    @(negedge clk);
    bus_if.sel = 1'b0;
    bus_if.rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic busy_seen;
    reset_b = 1'b0;
    rxd = 1'b1;
    bus_if.sel = 1'b0;
    bus_if.rd = 1'b0;
    bus_if.a = 1'b1;
    #1000;
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h want=%h", v, 16'h0000); end
    total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", bus_if.irq); end
    peek(1'b0, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=%h", v, 16'h0000); end
    @(negedge clk);
    reset_b = 1'b1;
    bus_if.a = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_if.dout[7] !== 1'b0 || bus_if.irq !== 1'b0) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy_seen); end
  endtask

  task automatic test_single();
    logic [15:0] v;
    logic [7:0] e;
    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    total++; if (bus_if.irq !== 1'b1) begin bad++; $display("FAIL single_irq_rise got=%b want=1", bus_if.irq); end
    peek(1'b1, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL single_status got=%h want=%h", v, 16'h0003); end
    read_reg(1'b0, v);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL single_data got=%h want=<none>", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== {8'h00, e}) begin bad++; $display("FAIL single_data got=%h want=%h", v, {8'h00, e}); end
    end
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL single_status_after got=%h want=%h", v, 16'h0000); end
    total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL single_irq_fall got=%b want=0", bus_if.irq); end
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    logic [7:0] e;
    logic [7:0] bytes [5];
    bytes = '{8'h03, 8'h02, 8'h04, 8'h12, 8'h34};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1);
    end
    peek(1'b1, v);
    total++; if (v !== 16'h0019) begin bad++; $display("FAIL ovr_status got=%h want=%h", v, 16'h0019); end
    total++; if (bus_if.irq !== 1'b1) begin bad++; $display("FAIL ovr_irq got=%b want=1", bus_if.irq); end
    for (int i = 0; i < 4; i++) begin
      read_reg(1'b0, v);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL ovr_data got=%h want=<none>", v); end
      else begin
        e = exp_q.pop_front();
        if (v !== {8'h00, e}) begin bad++; $display("FAIL ovr_data got=%h want=%h", v, {8'h00, e}); end
      end
    end
    read_reg(1'b1, v);
    total++; if (v !== 16'h0010) begin bad++; $display("FAIL ovr_flag_read got=%h want=%h", v, 16'h0010); end
    read_reg(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL ovr_flag_cleared got=%h want=%h", v, 16'h0000); end
  endtask

  task automatic test_framing();
    logic [15:0] v;
    send_frame(8'h56, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    peek(1'b1, v);
    total++; if (v !== 16'h00A0) begin bad++; $display("FAIL ferr_break got=%h want=%h", v, 16'h00A0); end
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    peek(1'b1, v);
    total++; if (v !== 16'h0020) begin bad++; $display("FAIL ferr_idle got=%h want=%h", v, 16'h0020); end
    read_reg(1'b1, v);
    total++; if (v !== 16'h0020) begin bad++; $display("FAIL ferr_read got=%h want=%h", v, 16'h0020); end
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL ferr_cleared got=%h want=%h", v, 16'h0000); end
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL glitch_status got=%h want=%h", v, 16'h0000); end
    total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b want=0", bus_if.irq); end
  endtask

  task automatic test_push_pop_full();
    logic [15:0] v;
    logic [15:0] rv;
    logic [7:0] e;
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1);
    end
    peek(1'b1, v);
    total++; if (v !== 16'h0009) begin bad++; $display("FAIL full_status got=%h want=%h", v, 16'h0009); end
    exp_q.push_back(8'h78);
    rv = '0;
    fork
      send_frame(8'h78, 1'b1);
      begin
        @(negedge clk);
        repeat (STOP_NEG) @(negedge clk);
        bus_if.a = 1'b0;
        bus_if.sel = 1'b1;
        bus_if.rd = 1'b1;
        #10 rv = bus_if.dout;
        @(negedge clk);
        bus_if.sel = 1'b0;
        bus_if.rd = 1'b0;
      end
    join
    e = exp_q.pop_front();
    total++; if (rv !== {8'h00, e}) begin bad++; $display("FAIL pushpop_data got=%h want=%h", rv, {8'h00, e}); end
    peek(1'b1, v);
    total++; if (v !== 16'h0009) begin bad++; $display("FAIL pushpop_status got=%h want=%h", v, 16'h0009); end
    for (int i = 0; i < 4; i++) begin
      read_reg(1'b0, v);
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL pushpop_drain got=%h want=<none>", v); end
      else begin
        e = exp_q.pop_front();
        if (v !== {8'h00, e}) begin bad++; $display("FAIL pushpop_drain got=%h want=%h", v, {8'h00, e}); end
      end
    end
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL pushpop_empty got=%h want=%h", v, 16'h0000); end
  endtask

  task automatic test_midframe_reset();
    logic [15:0] v;
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rxd = 1'b1;
    reset_b = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    peek(1'b1, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL midreset_status got=%h want=%h", v, 16'h0000); end
    total++; if (bus_if.irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b want=0", bus_if.irq); end
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    peek(1'b0, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL midreset_data got=%h want=%h", v, 16'h0000); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [15:0] v;
    logic [7:0] e;
    par_flip = 1'b1;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    par_flip = 1'b0;
    peek(1'b1, v);
    total++; if (v !== 16'h0043) begin bad++; $display("FAIL perr_status got=%h want=%h", v, 16'h0043); end
    read_reg(1'b0, v);
    e = exp_q.pop_front();
    total++; if (v !== {8'h00, e}) begin bad++; $display("FAIL perr_data got=%h want=%h", v, {8'h00, e}); end
    read_reg(1'b1, v);
    total++; if (v !== 16'h0040) begin bad++; $display("FAIL perr_read got=%h want=%h", v, 16'h0040); end
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    peek(1'b1, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL par_good_status got=%h want=%h", v, 16'h0003); end
    read_reg(1'b0, v);
    e = exp_q.pop_front();
    total++; if (v !== {8'h00, e}) begin bad++; $display("FAIL par_good_data got=%h want=%h", v, {8'h00, e}); end
  endtask
`endif

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_push_pop_full();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
